// File: rtl/kamikaze_ibuf.sv
// kamikaze_ibuf: fetch-to-decode instruction queue.
// First-word fall-through circular buffer with flush.
module kamikaze_ibuf #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [31:0]              instr_i,
  input  logic                     instr_valid_i,
  input  logic                     is_compressed_instr_i,
  input  logic [31:0]              pc_i,
  output logic                     stall_o,
  input  logic                     flush_i,
  output logic [31:0]              instr_o,
  output logic [31:0]              pc_o,
  output logic                     is_compressed_instr_o,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        cmp;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (cnt == FULL);
  assign empty = (cnt == '0);
  assign push  = instr_valid_i && !full && !flush_i;
  assign pop   = !empty && instr_ready_i && !flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is never reset; outputs are masked while empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr] <= '{instr: instr_i,
                     pc:    pc_i,
                     cmp:   is_compressed_instr_i};
    end
  end

  assign head = mem[rptr];

  assign stall_o               = full;
  assign count_o               = cnt;
  assign instr_valid_o         = !empty;
  assign instr_o               = empty ? '0 : head.instr;
  assign pc_o                  = empty ? '0 : head.pc;
  assign is_compressed_instr_o = empty ? 1'b0 : head.cmp;

endmodule

// File: tb/tb_kamikaze_ibuf.sv
// tb_kamikaze_ibuf: random + directed checks against
// a queue-based reference model of the instruction buffer.
module tb_kamikaze_ibuf;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 0;
  logic          rst = 0;
  logic [31:0]   instr_i = 0;
  logic          valid_i = 0;
  logic          cmp_i = 0;
  logic [31:0]   pc_i = 0;
  logic          stall;
  logic          flush = 0;
  logic [31:0]   instr_o;
  logic [31:0]   pc_o;
  logic          cmp_o;
  logic          valid_o;
  logic          ready = 0;
  logic [CW-1:0] count;

  kamikaze_ibuf #(.DEPTH(DEPTH)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .instr_i               (instr_i),
    .instr_valid_i         (valid_i),
    .is_compressed_instr_i (cmp_i),
    .pc_i                  (pc_i),
    .stall_o               (stall),
    .flush_i               (flush),
    .instr_o               (instr_o),
    .pc_o                  (pc_o),
    .is_compressed_instr_o (cmp_o),
    .instr_valid_o         (valid_o),
    .instr_ready_i         (ready),
    .count_o               (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        cmp;
  } ent_t;

  ent_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic check_outs(input string tag);
    int n;
    n = q.size();
    check({tag, ".count"}, 64'(count), 64'(n));
    check({tag, ".valid"}, 64'(valid_o), 64'(n != 0));
    check({tag, ".stall"}, 64'(stall), 64'(n == DEPTH));
    check({tag, ".instr"}, 64'(instr_o),
          n != 0 ? 64'(q[0].instr) : 64'd0);
    check({tag, ".pc"}, 64'(pc_o),
          n != 0 ? 64'(q[0].pc) : 64'd0);
    check({tag, ".cmp"}, 64'(cmp_o),
          n != 0 ? 64'(q[0].cmp) : 64'd0);
  endtask

  // Check at negedge, then advance model across posedge.
  task automatic step(input string tag);
    bit do_push, do_pop;
    ent_t e;
    @(negedge clk);
    check_outs(tag);
    do_push = valid_i && q.size() < DEPTH && !flush;
    do_pop  = ready && q.size() > 0 && !flush;
    e.instr = instr_i;
    e.pc    = pc_i;
    e.cmp   = cmp_i;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic c, input logic r,
                       input logic f);
    valid_i = v;
    pc_i    = pc;
    instr_i = $urandom;
    cmp_i   = c;
    ready   = r;
    flush   = f;
  endtask

  initial begin
    #2;
    check_outs("reset");
    #10;
    rst = 1;
    @(posedge clk);
    #1;

    // single push
    drive(1, 32'h4, 0, 0, 0);
    instr_i = 32'h0000_0013;
    step("push1");
    drive(0, 0, 0, 0, 0);
    step("push1_vis");
    check("push1.pc", 64'(pc_o), 64'h4);
    check("push1.instr", 64'(instr_o), 64'h13);
    drive(0, 0, 0, 1, 0);
    step("push1_pop");

    // fill, overflow attempt, drain
    drive(1, 32'h0, 1, 0, 0); step("fill0");
    drive(1, 32'h2, 0, 0, 0); step("fill1");
    drive(1, 32'h6, 1, 0, 0); step("fill2");
    drive(1, 32'h8, 1, 0, 0); step("fill3");
    drive(1, 32'hA, 0, 0, 0); step("fill_ovf");
    check("full.stall", 64'(stall), 64'd1);
    check("full.count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0);
      step("drain");
    end
    check("drained.count", 64'(count), 64'd0);

    // steady stream
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h1000 + 32'(i * 4), i[0], 1, 0);
      step("stream");
    end
    drive(0, 0, 0, 1, 0);
    step("stream_end");

    // flush with simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h200 + 32'(i * 4), 0, 0, 0);
      step("pre_flush");
    end
    drive(1, 32'h300, 1, 1, 1);
    step("flush");
    drive(0, 0, 0, 0, 0);
    step("post_flush");
    check("flush.valid", 64'(valid_o), 64'd0);
    check("flush.pc", 64'(pc_o), 64'd0);
    drive(1, 32'h100, 0, 0, 0);
    step("push100");
    drive(0, 0, 0, 0, 0);
    step("head100");
    check("flush.head", 64'(pc_o), 64'h100);

    // full + push + pop
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h400 + 32'(i * 4), 0, 0, 0);
      step("fill_b");
    end
    drive(1, 32'h500, 0, 1, 0);
    step("full_pp");
    drive(0, 0, 0, 0, 0);
    step("full_pp_after");
    check("fullpp.count", 64'(count), 64'd3);
    check("fullpp.stall", 64'(stall), 64'd0);

    // async reset between edges at count 2
    drive(0, 0, 0, 1, 0);
    step("to2");
    check("pre_rst.count", 64'(count), 64'd2);
    drive(0, 0, 0, 0, 0);
    #2;
    rst = 0;
    #1;
    q.delete();
    check_outs("async_rst");
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    drive(1, 32'h700, 1, 0, 0);
    step("post_rst_push");
    drive(0, 0, 0, 0, 0);
    step("post_rst_head");

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 9) < 7,
            $urandom & 32'hFFFF_FFFE,
            $urandom_range(0, 1),
            $urandom_range(0, 1),
            $urandom_range(0, 99) < 3);
      step("rand");
    end
    drive(0, 0, 0, 0, 0);
    step("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/kamikaze_ibuf.md
KAMIKAZE_IBUF -- requirements
Module: kamikaze_ibuf

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; legal values are powers of two, 2..16.
REQ-002 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 instr_i  input  32  expanded instruction from fetch stage.
REQ-005 instr_valid_i  input  1  instr_i/pc_i/is_compressed_instr_i valid this cycle.
REQ-006 is_compressed_instr_i  input  1  instruction originated as 16-bit RVC.
REQ-007 pc_i  input  32  PC of instr_i.
REQ-008 stall_o  output  1  fetch must hold its PC and outputs this cycle.
REQ-009 flush_i  input  1  discard all queued entries (branch/exception redirect).
REQ-010 instr_o  output  32  head-entry instruction to decode.
REQ-011 pc_o  output  32  head-entry PC.
REQ-012 is_compressed_instr_o  output  1  head-entry RVC flag.
REQ-013 instr_valid_o  output  1  head entry present.
REQ-014 instr_ready_i  input  1  decode accepts head entry this cycle.
REQ-015 count_o  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-016 Circular buffer of DEPTH entries {instr, pc, compressed}, write pointer, read pointer, occupancy counter; pointers log2(DEPTH) bits, wrap modulo DEPTH.
REQ-017 stall_o SHALL equal (count_o == DEPTH), combinational from registered count only; no dependence on instr_ready_i.
REQ-018 Push SHALL occur when instr_valid_i && !stall_o && !flush_i; entry written at write pointer, write pointer +1.
REQ-019 Pop SHALL occur when instr_valid_o && instr_ready_i && !flush_i; read pointer +1.
REQ-020 instr_valid_o SHALL equal (count_o != 0); first-word fall-through: instr_o/pc_o/is_compressed_instr_o driven combinationally from entry at read pointer.
REQ-021 While instr_valid_o = 0, instr_o, pc_o, is_compressed_instr_o SHALL be 0.
REQ-022 Latency: an entry pushed in cycle N SHALL be visible on outputs in cycle N+1 (no input-to-output bypass).
REQ-023 Push and pop in same cycle: count unchanged, both pointers advance.
REQ-024 Full: push ignored even if pop occurs same cycle (stall_o already 1); count becomes DEPTH-1 after the pop.
REQ-025 Empty: instr_ready_i ignored; a simultaneous push makes count 1 next cycle.
REQ-026 Flush: count, both pointers SHALL be 0 next cycle; same-cycle push and pop discarded; instr_valid_o = 0 next cycle; flush has priority over all other events.
REQ-027 Order SHALL be strict FIFO; entries never reordered, duplicated or dropped except by flush.
REQ-028 count_o SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-029 On rst_i low, asynchronously: count_o = 0, pointers = 0, instr_valid_o = 0, stall_o = 0, instr_o = pc_o = 0, is_compressed_instr_o = 0.
REQ-030 Entry storage need not be reset; outputs masked per REQ-021.
REQ-031 Reset asserted mid-operation SHALL discard all entries; first push after release lands at pointer 0.

Verification
REQ-032 Single push: pc_i=0x4, instr_i=0x00000013, valid 1 cycle, ready=0 -> next cycle instr_valid_o=1, pc_o=0x4, instr_o=0x00000013, count_o=1.
REQ-033 Fill DEPTH=4 with pc 0x0,0x2,0x6,0x8 (compressed 1,0,1,1), ready=0 -> stall_o=1, count_o=4; fifth push pc 0xA ignored; ready=1 drains 0x0,0x2,0x6,0x8 in order with matching flags.
REQ-034 Steady stream, valid=1 and ready=1 every cycle for 20 cycles -> count_o stays 1 after first cycle, one instruction per cycle, PCs in order, wrap of pointers exercised.
REQ-035 Count 3, flush_i=1 with simultaneous push and ready -> next cycle count_o=0, instr_valid_o=0, outputs 0; subsequent push pc 0x100 appears as head.
REQ-036 Full queue, ready=1 and valid=1 same cycle -> head popped, input not accepted, count_o=3, stall_o=0 next cycle.
REQ-037 rst_i low asynchronously between clock edges at count 2 -> outputs per REQ-029 immediately, without waiting for clk_i.
